// File: rtl/rr_dispatcher_pkg.sv
// Shared helpers for the round-robin dispatcher and its priority picker.
package rr_dispatcher_pkg;

  // Port-index width, never narrower than one bit so a single-port build still has a signal.
  function automatic int port_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin select: lowest available index at or above ptr, else lowest overall.
module rr_pick
  import rr_dispatcher_pkg::*;
#(
  parameter int NUM_PORTS = 8,
  parameter int PORT_W    = port_width(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] avail,
  input  logic [PORT_W-1:0]    ptr,
  output logic [PORT_W-1:0]    pick,
  output logic                 pick_valid
);

  logic [PORT_W-1:0] masked_idx;
  logic [PORT_W-1:0] any_idx;
  logic              masked_hit;
  logic              any_hit;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    masked_idx = '0;
    any_idx    = '0;
    masked_hit = 1'b0;
    any_hit    = 1'b0;
    // Scan downward so the last hit written is the lowest index.
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (avail[i]) begin
        any_idx = PORT_W'(i);
        any_hit = 1'b1;
        if (PORT_W'(i) >= ptr) begin
          masked_idx = PORT_W'(i);
          masked_hit = 1'b1;
        end
      end
    end
    pick       = masked_hit ? masked_idx : any_idx;
    pick_valid = any_hit;
  end

endmodule

// File: rtl/rr_dispatcher.sv
// Packet-granular round-robin fan-out: one upstream stream spread over NUM_PORTS engines,
// with a one-beat registered holding stage and per-packet port locking.
module rr_dispatcher
  import rr_dispatcher_pkg::*;
#(
  parameter int NUM_PORTS = 8,
  parameter int DWIDTH    = 512,
  parameter int EMPTY_W   = 6,
  parameter int PORT_W    = port_width(NUM_PORTS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DWIDTH-1:0]    in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_sop,
  input  logic                 in_eop,
  input  logic [EMPTY_W-1:0]   in_empty,
  input  logic [NUM_PORTS-1:0] eng_avail,
  output logic [DWIDTH-1:0]    out_data,
  output logic                 out_sop,
  output logic                 out_eop,
  output logic [EMPTY_W-1:0]   out_empty,
  output logic [NUM_PORTS-1:0] out_valid,
  input  logic [NUM_PORTS-1:0] out_ready,
  output logic [PORT_W-1:0]    cur_port,
  output logic                 err_pulse,
  output logic [31:0]          pkt_cnt
);

  typedef enum logic {IDLE, BUSY} state_e;

  typedef struct packed {
    logic [DWIDTH-1:0]  data;
    logic               sop;
    logic               eop;
    logic [EMPTY_W-1:0] empty;
  } beat_t;

  state_e            state_q, state_d;
  logic [PORT_W-1:0] ptr_q, ptr_d;
  logic [PORT_W-1:0] sel_q, sel_d;
  logic              hold_valid_q, hold_valid_d;
  logic [PORT_W-1:0] hold_port_q, hold_port_d;
  beat_t             hold_q, hold_d;
  logic              err_q, err_d;
  logic [31:0]       pkt_cnt_q, pkt_cnt_d;

  logic [PORT_W-1:0] pick;
  logic              pick_valid;
  logic              drain;
  logic              route_ok;
  logic              accept;
  logic              fwd;
  logic [PORT_W-1:0] fwd_port;

  rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .PORT_W    (PORT_W)
  ) u_pick (
    .avail      (eng_avail),
    .ptr        (ptr_q),
    .pick       (pick),
    .pick_valid (pick_valid)
  );

  // A new sop in IDLE waits for an engine; stray non-sop beats are always taken so they can be dropped.
  assign drain    = hold_valid_q && out_ready[hold_port_q];
  assign route_ok = (state_q == BUSY) || !in_sop || pick_valid;
  assign in_ready = (!hold_valid_q || out_ready[hold_port_q]) && route_ok;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    sel_d        = sel_q;
    hold_valid_d = hold_valid_q && !drain;
    hold_port_d  = hold_port_q;
    hold_d       = hold_q;
    err_d        = 1'b0;
    pkt_cnt_d    = pkt_cnt_q;
    fwd          = 1'b0;
    fwd_port     = sel_q;

    if (accept) begin
      unique case (state_q)
        IDLE: begin
          if (in_sop) begin
            fwd      = 1'b1;
            fwd_port = pick;
            ptr_d    = (pick == PORT_W'(NUM_PORTS - 1)) ? '0 : pick + PORT_W'(1);
            if (!in_eop) begin
              state_d = BUSY;
              sel_d   = pick;
            end
          end else begin
            err_d = 1'b1;
          end
        end
        BUSY: begin
          if (in_sop) begin
            err_d = 1'b1;
          end else begin
            fwd = 1'b1;
            if (in_eop) state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (fwd) begin
      hold_valid_d = 1'b1;
      hold_port_d  = fwd_port;
      hold_d       = '{data: in_data, sop: in_sop, eop: in_eop, empty: in_empty};
      if (in_eop) pkt_cnt_d = pkt_cnt_q + 32'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      sel_q        <= '0;
      hold_valid_q <= 1'b0;
      hold_port_q  <= '0;
      // NOTE: the wide data register is reset too because the outputs must read zero out of reset.
      hold_q       <= '0;
      err_q        <= 1'b0;
      pkt_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      sel_q        <= sel_d;
      hold_valid_q <= hold_valid_d;
      hold_port_q  <= hold_port_d;
      hold_q       <= hold_d;
      err_q        <= err_d;
      pkt_cnt_q    <= pkt_cnt_d;
    end
  end

  always_comb begin
    out_valid = '0;
    if (hold_valid_q) out_valid[hold_port_q] = 1'b1;
  end

  assign out_data  = hold_q.data;
  assign out_sop   = hold_q.sop;
  assign out_eop   = hold_q.eop;
  assign out_empty = hold_q.empty;
  assign cur_port  = hold_port_q;
  assign err_pulse = err_q;
  assign pkt_cnt   = pkt_cnt_q;

endmodule

// File: tb/tb_rr_dispatcher.sv
// Directed bench for rr_dispatcher: each task drives one scenario and checks hand-computed values.
module tb_rr_dispatcher;

  localparam int NUM_PORTS = 8;
  localparam int DWIDTH    = 512;
  localparam int EMPTY_W   = 6;
  localparam int PORT_W    = 3;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [DWIDTH-1:0]    in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic                 in_sop;
  logic                 in_eop;
  logic [EMPTY_W-1:0]   in_empty;
  logic [NUM_PORTS-1:0] eng_avail;
  logic [DWIDTH-1:0]    out_data;
  logic                 out_sop;
  logic                 out_eop;
  logic [EMPTY_W-1:0]   out_empty;
  logic [NUM_PORTS-1:0] out_valid;
  logic [NUM_PORTS-1:0] out_ready;
  logic [PORT_W-1:0]    cur_port;
  logic                 err_pulse;
  logic [31:0]          pkt_cnt;

  int vectors     = 0;
  int miscompares = 0;

  rr_dispatcher #(
    .NUM_PORTS (NUM_PORTS),
    .DWIDTH    (DWIDTH),
    .EMPTY_W   (EMPTY_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sop    (in_sop),
    .in_eop    (in_eop),
    .in_empty  (in_empty),
    .eng_avail (eng_avail),
    .out_data  (out_data),
    .out_sop   (out_sop),
    .out_eop   (out_eop),
    .out_empty (out_empty),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .cur_port  (cur_port),
    .err_pulse (err_pulse),
    .pkt_cnt   (pkt_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic sop, input logic eop, input logic [31:0] d);
    in_valid = v;
    in_sop   = sop;
    in_eop   = eop;
    in_data  = DWIDTH'(d);
    in_empty = d[EMPTY_W-1:0];
  endtask

  task automatic test_reset();
    rst = 1'b1; out_ready = '1; eng_avail = '1;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    tick(); tick();
    vectors++; if (out_valid !== 8'h00) begin miscompares++; $display("FAIL reset_out_valid got %h exp %h", out_valid, 8'h00); end
    vectors++; if (pkt_cnt !== 32'd0) begin miscompares++; $display("FAIL reset_pkt_cnt got %0d exp %0d", pkt_cnt, 0); end
    vectors++; if (cur_port !== 3'd0) begin miscompares++; $display("FAIL reset_cur_port got %0d exp %0d", cur_port, 0); end
    vectors++; if (err_pulse !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b exp %b", err_pulse, 1'b0); end
    vectors++; if ({out_data, out_sop, out_eop, out_empty} !== '0) begin miscompares++; $display("FAIL reset_out_beat got %0h exp 0", out_data); end
    rst = 1'b0;
    tick();
  endtask

  // Three single-beat packets, all engines free: ports 0,1,2 on consecutive cycles.
  task automatic test_back_to_back();
    eng_avail = 8'hFF; out_ready = 8'hFF;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b1, 1'b1, 32'h10 + k);
      #1;
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_in_ready[%0d] got %b exp 1", k, in_ready); end
      tick();
      vectors++; if (out_valid !== 8'(1 << k)) begin miscompares++; $display("FAIL b2b_out_valid[%0d] got %h exp %h", k, out_valid, 8'(1 << k)); end
      vectors++; if (out_data !== DWIDTH'(32'h10 + k)) begin miscompares++; $display("FAIL b2b_out_data[%0d] got %0h exp %0h", k, out_data, 32'h10 + k); end
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    vectors++; if (pkt_cnt !== 32'd3) begin miscompares++; $display("FAIL b2b_pkt_cnt got %0d exp 3", pkt_cnt); end
    vectors++; if (out_empty !== 6'h12) begin miscompares++; $display("FAIL b2b_out_empty got %h exp %h", out_empty, 6'h12); end
    tick();
    vectors++; if (out_valid !== 8'h00) begin miscompares++; $display("FAIL b2b_drained got %h exp 00", out_valid); end
  endtask

  // ptr=3: avail 0x11 -> 4; avail 0x01 -> wrap to 0; avail 0 blocks sop; avail 0x80 -> 7.
  task automatic test_avail_mask();
    eng_avail = 8'h11;
    drive(1'b1, 1'b1, 1'b1, 32'h20);
    tick();
    vectors++; if (out_valid !== 8'h10) begin miscompares++; $display("FAIL mask_port4 got %h exp 10", out_valid); end
    vectors++; if (cur_port !== 3'd4) begin miscompares++; $display("FAIL mask_cur_port4 got %0d exp 4", cur_port); end
    eng_avail = 8'h01;
    drive(1'b1, 1'b1, 1'b1, 32'h21);
    tick();
    vectors++; if (out_valid !== 8'h01) begin miscompares++; $display("FAIL mask_wrap0 got %h exp 01", out_valid); end
    eng_avail = 8'h00;
    drive(1'b1, 1'b1, 1'b1, 32'h22);
    #1;
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL mask_noavail_ready got %b exp 0", in_ready); end
    tick();
    vectors++; if (out_valid !== 8'h00) begin miscompares++; $display("FAIL mask_noavail_valid got %h exp 00", out_valid); end
    eng_avail = 8'h80;
    #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL mask_avail7_ready got %b exp 1", in_ready); end
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    vectors++; if (out_valid !== 8'h80) begin miscompares++; $display("FAIL mask_port7 got %h exp 80", out_valid); end
    vectors++; if (out_data !== DWIDTH'(32'h22)) begin miscompares++; $display("FAIL mask_port7_data got %0h exp 22", out_data); end
    vectors++; if (pkt_cnt !== 32'd6) begin miscompares++; $display("FAIL mask_pkt_cnt got %0d exp 6", pkt_cnt); end
    tick();
  endtask

  // ptr=0, avail 0x02 locks port 1; stall two cycles with avail dropped to 0 mid-packet.
  task automatic test_stall();
    eng_avail = 8'h02; out_ready = 8'hFF;
    drive(1'b1, 1'b1, 1'b0, 32'hA0);
    tick();
    vectors++; if (out_valid !== 8'h02 || out_data !== DWIDTH'(32'hA0)) begin miscompares++; $display("FAIL stall_b0 got %h/%0h exp 02/a0", out_valid, out_data); end
    eng_avail = 8'h00;
    drive(1'b1, 1'b0, 1'b0, 32'hA1);
    #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL stall_busy_ready got %b exp 1", in_ready); end
    tick();
    out_ready = 8'hFD;
    drive(1'b1, 1'b0, 1'b0, 32'hA2);
    for (int c = 0; c < 2; c++) begin
      #1;
      vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL stall_ready[%0d] got %b exp 0", c, in_ready); end
      vectors++; if (out_valid !== 8'h02 || out_data !== DWIDTH'(32'hA1)) begin miscompares++; $display("FAIL stall_hold[%0d] got %h/%0h exp 02/a1", c, out_valid, out_data); end
      tick();
    end
    out_ready = 8'hFF;
    vectors++; if (out_valid !== 8'h02 || out_data !== DWIDTH'(32'hA1)) begin miscompares++; $display("FAIL stall_hold_end got %h/%0h exp 02/a1", out_valid, out_data); end
    tick();
    vectors++; if (out_valid !== 8'h02 || out_data !== DWIDTH'(32'hA2)) begin miscompares++; $display("FAIL stall_b2 got %h/%0h exp 02/a2", out_valid, out_data); end
    drive(1'b1, 1'b0, 1'b1, 32'hA3);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    vectors++; if (out_valid !== 8'h02 || out_data !== DWIDTH'(32'hA3) || out_eop !== 1'b1) begin miscompares++; $display("FAIL stall_b3 got %h/%0h/%b exp 02/a3/1", out_valid, out_data, out_eop); end
    tick();
    vectors++; if (out_valid !== 8'h00) begin miscompares++; $display("FAIL stall_drained got %h exp 00", out_valid); end
    vectors++; if (pkt_cnt !== 32'd7) begin miscompares++; $display("FAIL stall_pkt_cnt got %0d exp 7", pkt_cnt); end
  endtask

  // ptr=2 in IDLE: stray non-sop beat is dropped with a one-cycle error; ptr stays 2.
  task automatic test_err_idle();
    eng_avail = 8'hFF;
    drive(1'b1, 1'b0, 1'b1, 32'hB0);
    #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL erridle_ready got %b exp 1", in_ready); end
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    vectors++; if (err_pulse !== 1'b1) begin miscompares++; $display("FAIL erridle_err got %b exp 1", err_pulse); end
    vectors++; if (out_valid !== 8'h00) begin miscompares++; $display("FAIL erridle_valid got %h exp 00", out_valid); end
    tick();
    vectors++; if (err_pulse !== 1'b0) begin miscompares++; $display("FAIL erridle_err_clear got %b exp 0", err_pulse); end
    vectors++; if (pkt_cnt !== 32'd7) begin miscompares++; $display("FAIL erridle_pkt_cnt got %0d exp 7", pkt_cnt); end
    drive(1'b1, 1'b1, 1'b1, 32'hB1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    vectors++; if (out_valid !== 8'h04) begin miscompares++; $display("FAIL erridle_ptr_kept got %h exp 04", out_valid); end
    tick();
  endtask

  // ptr=3: packet locks port 3; an sop mid-packet is dropped and flagged, the rest still goes to 3.
  task automatic test_sop_in_busy();
    eng_avail = 8'hFF;
    drive(1'b1, 1'b1, 1'b0, 32'hC0);
    tick();
    vectors++; if (out_valid !== 8'h08) begin miscompares++; $display("FAIL busy_lock got %h exp 08", out_valid); end
    drive(1'b1, 1'b1, 1'b0, 32'hC1);
    tick();
    vectors++; if (err_pulse !== 1'b1) begin miscompares++; $display("FAIL busy_err got %b exp 1", err_pulse); end
    vectors++; if (out_valid !== 8'h00) begin miscompares++; $display("FAIL busy_drop got %h exp 00", out_valid); end
    drive(1'b1, 1'b0, 1'b0, 32'hC2);
    tick();
    vectors++; if (out_valid !== 8'h08 || out_data !== DWIDTH'(32'hC2)) begin miscompares++; $display("FAIL busy_mid got %h/%0h exp 08/c2", out_valid, out_data); end
    drive(1'b1, 1'b0, 1'b1, 32'hC3);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    vectors++; if (out_valid !== 8'h08 || out_eop !== 1'b1 || out_data !== DWIDTH'(32'hC3)) begin miscompares++; $display("FAIL busy_eop got %h/%b/%0h exp 08/1/c3", out_valid, out_eop, out_data); end
    vectors++; if (pkt_cnt !== 32'd9) begin miscompares++; $display("FAIL busy_pkt_cnt got %0d exp 9", pkt_cnt); end
    tick();
  endtask

  // ptr=4: lock port 4 and hold the beat, then reset; next sop with avail 0x21 must pick port 0.
  task automatic test_reset_mid();
    eng_avail = 8'hFF; out_ready = 8'h00;
    drive(1'b1, 1'b1, 1'b0, 32'hD0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    vectors++; if (out_valid !== 8'h10) begin miscompares++; $display("FAIL rstmid_held got %h exp 10", out_valid); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++; if (out_valid !== 8'h00) begin miscompares++; $display("FAIL rstmid_valid got %h exp 00", out_valid); end
    vectors++; if (cur_port !== 3'd0 || pkt_cnt !== 32'd0) begin miscompares++; $display("FAIL rstmid_regs got %0d/%0d exp 0/0", cur_port, pkt_cnt); end
    eng_avail = 8'h21; out_ready = 8'hFF;
    drive(1'b1, 1'b1, 1'b1, 32'hD1);
    #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rstmid_ready got %b exp 1", in_ready); end
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    vectors++; if (out_valid !== 8'h01 || out_data !== DWIDTH'(32'hD1)) begin miscompares++; $display("FAIL rstmid_port0 got %h/%0h exp 01/d1", out_valid, out_data); end
    vectors++; if (pkt_cnt !== 32'd1) begin miscompares++; $display("FAIL rstmid_pkt_cnt got %0d exp 1", pkt_cnt); end
    tick();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_avail_mask();
    test_stall();
    test_err_idle();
    test_sop_in_busy();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rr_dispatcher.md
Name: rr_dispatcher

Overview:
- Packet-granular round-robin distributor. One upstream stream is spread across NUM_PORTS string-matcher engines.
- It is the fan-out counterpart of the engine-side round-robin arbiter: that arbiter merges N requesters to one; this block splits one stream to N.
- Sits between the packet parser and the matcher engine array. Once a packet starts on a port, all of its beats go to that port.

Parameters:
- NUM_PORTS, 8, number of downstream engines (>=1, need not be a power of 2)
- DWIDTH, 512, beat data width
- EMPTY_W, 6, width of the empty-byte field
- PORT_W, $clog2(NUM_PORTS) (min 1), width of the port index

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_data  in  DWIDTH  beat data
- in_valid  in  1  beat valid
- in_ready  out  1  beat accepted when in_valid&in_ready
- in_sop  in  1  first beat of packet
- in_eop  in  1  last beat of packet
- in_empty  in  EMPTY_W  empty bytes, valid on eop
- eng_avail  in  NUM_PORTS  engine i can start a new packet
- out_data  out  DWIDTH  broadcast data
- out_sop  out  1  broadcast sop
- out_eop  out  1  broadcast eop
- out_empty  out  EMPTY_W  broadcast empty
- out_valid  out  NUM_PORTS  one-hot valid for the target engine
- out_ready  in  NUM_PORTS  per-engine ready
- cur_port  out  PORT_W  port of the held beat
- err_pulse  out  1  one-cycle protocol-error flag
- pkt_cnt  out  32  packets dispatched, wraps

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - hold_valid=0, so out_valid=0.
  - state=IDLE, ptr=0, err_pulse=0, pkt_cnt=0, cur_port=0.
  - out_data, out_sop, out_eop and out_empty are 0.
- Reset mid-packet: the held beat is discarded and the lock is released. Nothing is emitted on the cycle after reset.
- Holding register: one beat deep, registered output, latency 1 cycle from input accept to out_valid.
  - out_valid[i] = hold_valid && hold_port==i.
  - The held beat drains when out_ready[hold_port]=1.
- in_ready = (~hold_valid | out_ready[hold_port]) && route_ok.
  - Fill and drain in the same cycle are allowed, giving full throughput.
- route_ok:
  - BUSY: 1.
  - IDLE with in_sop: 1 when |eng_avail.
  - IDLE without in_sop: 1 (the beat is accepted for drop).
- State machine:
  - IDLE, on accepted sop&~eop: lock sel=pick, go to BUSY.
  - IDLE, on accepted sop&eop: forward the beat to pick and stay IDLE.
  - BUSY, on accepted beat without sop: forward to sel; on eop go to IDLE.
  - BUSY, on accepted sop: drop the beat, err_pulse=1, stay BUSY.
  - IDLE, on accepted non-sop beat: drop the beat, err_pulse=1, state and ptr unchanged.
- Pick, evaluated only at an accepted sop in IDLE:
  - Masked request = eng_avail & (ports >= ptr). Take the lowest set index.
  - If the masked request is empty, take the lowest set index of eng_avail. This is the wrap case.
  - ptr <= pick+1; if pick = NUM_PORTS-1, ptr <= 0.
  - eng_avail changes after the lock are ignored until eop.
- pkt_cnt increments by 1 at each accepted eop that is forwarded; dropped beats do not count. It wraps from 2^32-1 to 0.
- out_valid is never withdrawn before the held beat is taken, and the held beat is stable while stalled.
- NUM_PORTS=1: pick is always 0 and ptr stays 0.

Decomposition:
- Package: no shared typedefs; the beat struct (data, sop, eop, empty) and the state enum (IDLE, BUSY) are defined locally in the module.
- Sub-module rr_pick, combinational:
  - Inputs: avail[NUM_PORTS], ptr.
  - Outputs: pick index, pick_valid.
  - Performs the masked/unmasked lowest-index priority select. Reusable by the arbiter side.

Test Plan:
- Reset, eng_avail=8'hFF, out_ready=8'hFF, three single-beat packets back-to-back -> out_valid 8'h01, 8'h02, 8'h04 on consecutive cycles, each 1 cycle after accept; pkt_cnt=3.
- After the previous test (ptr=3), eng_avail=8'h11, send a single-beat packet -> port 4. Then eng_avail=8'h01 -> port 0 (wrap). Then eng_avail=8'h00 at sop -> in_ready=0; asserting eng_avail=8'h80 -> in_ready=1 and dispatch to port 7.
- 4-beat packet locked to port 1, out_ready[1]=0 for 2 cycles mid-packet, eng_avail toggled to 8'h00 -> in_ready low during stall, held beat stable, all 4 beats in order on port 1 only.
- Non-sop beat while IDLE -> accepted, no out_valid, err_pulse high exactly 1 cycle, pkt_cnt and ptr unchanged.
- sop beat while BUSY -> dropped, err_pulse=1; the current packet's later beats and eop still go to the locked port.
- rst asserted with a beat held and BUSY -> next cycle out_valid=0, state IDLE, ptr=0; the next sop goes to the lowest available port.
